// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes, sticky error
// bundle and the default bit timing.
package uart_pkg;

  // 100 MHz core clock at 115200 baud
  localparam int CLK_PER_BIT_DEF = 868;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  typedef struct packed {
    logic frame;
    logic parity;
    logic overrun;
  } rx_err_t;

  // Expected parity bit for the given data under the given mode.
  function automatic logic par_bit(input logic [7:0] d, input int mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with clock enable; shared by the RX and TX paths.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign rd_data = mem[rd_ptr];

  // A pop frees the slot at full, so a simultaneous push is still accepted.
  assign do_pop  = en && pop && valid;
  assign do_push = en && push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: mid-bit sampling FSM feeding a show-ahead RX
// FIFO, with sticky frame/parity/overrun flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = PAR_NONE,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clkEn,
  input  logic                         rx,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         frame_err,
  output logic                         parity_err,
  output logic                         overrun,
  input  logic                         err_clr
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLK_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic             LAST_STP = 1'(STOP_BITS - 1);

  rx_state_e              state;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   push_q;
  logic                   rx_meta, rx_s, rx_prev;
  logic                   tick, fall;
  rx_err_t                err_q, err_evt;
  logic [DATA_BITS-1:0]   fifo_rd;
  logic                   fifo_full;

  // rx_prev is a third stage used only to find the synchronized falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else if (clkEn) begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign tick = (cnt == '0);
  assign fall = rx_prev && !rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      push_q   <= 1'b0;
    end else if (clkEn) begin
      push_q <= 1'b0;
      if (state != S_IDLE) cnt <= tick ? FULL : cnt - 1'b1;
      unique case (state)
        S_IDLE: begin
          if (fall) begin
            state <= S_START;
            cnt   <= HALF;
          end
        end
        S_START: begin
          if (tick) begin
            // Line back high at mid start bit: a glitch, not a frame.
            if (rx_s) state <= S_IDLE;
            else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state    <= (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            state    <= S_STOP;
            stop_idx <= 1'b0;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (stop_idx == LAST_STP) begin
              state  <= S_IDLE;
              push_q <= 1'b1;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    err_evt         = '0;
    err_evt.frame   = clkEn && (state == S_STOP) && tick && !rx_s;
    err_evt.parity  = clkEn && (state == S_PARITY) && tick &&
                      (rx_s != par_bit(8'(shreg), PARITY));
    err_evt.overrun = clkEn && push_q && fifo_full && !(rx_valid && rx_ready);
  end

  // A new event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)        err_q <= '0;
    else if (clkEn) err_q <= err_evt | (err_clr ? '0 : err_q);
  end

  assign frame_err  = err_q.frame;
  assign parity_err = err_q.parity;
  assign overrun    = err_q.overrun;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .en        (clkEn),
    .push      (push_q),
    .push_data (shreg),
    .pop       (rx_ready),
    .rd_data   (fifo_rd),
    .valid     (rx_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign rx_data = 8'(fifo_rd);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: a default-parameter instance for 868-cycle timing
// and a fast even-parity/2-stop/depth-4 instance for random and corner traffic.
module tb_uart_rx_param;

  localparam int CPB0   = 868;
  localparam int CPB1   = 16;
  localparam int SB1    = 2;
  localparam int DEPTH1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       rx0, rdy0, en0, clr0;
  logic [7:0] d0;
  logic       v0, fe0, pe0, ov0;
  logic [4:0] cnt0;

  logic       rx1, rdy1, en1, clr1;
  logic [7:0] d1;
  logic       v1, fe1, pe1, ov1;
  logic [2:0] cnt1;

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 0;   // 0 low, 1 high, 2 random
  int en_mode  = 1;   // 0 low, 1 high, 2 random (mostly high)
  logic [7:0] exp_q [$];

  uart_rx_param u_dut0 (
    .clk(clk), .rst(rst), .clkEn(en0), .rx(rx0),
    .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0), .fifo_count(cnt0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .err_clr(clr0)
  );

  uart_rx_param #(
    .CLK_PER_BIT(CPB1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(SB1), .FIFO_DEPTH(DEPTH1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .clkEn(en1), .rx(rx1),
    .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1), .fifo_count(cnt1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .err_clr(clr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Consumer handshake and clock-enable pattern for the fast instance.
  initial begin
    rdy1 = 1'b0;
    en1  = 1'b1;
    forever begin
      @(posedge clk); #1;
      rdy1 = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
      en1  = (en_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'(en_mode);
    end
  end

  // Scoreboard monitor: every pop of the fast instance must match the model.
  always @(negedge clk) begin
    if (!rst && v1 && rdy1 && en1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual=%0h required=none", d1);
      end else begin
        chk("rx_data_pop", {24'h0, d1}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_en(input int which, input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if ((which == 0) ? en0 : en1) k++;
    end
    #2;
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  // Serial line model: start, LSB-first data, even parity on instance 1,
  // stop bits; bad_stop pulls the first stop bit low.
  task automatic send(input int which, input logic [7:0] data, input bit bad_par, input bit bad_stop);
    int   cpb   = (which == 0) ? CPB0 : CPB1;
    int   nstop = (which == 0) ? 1 : SB1;
    logic p     = (^data) ^ bad_par;
    drive(which, 1'b0); wait_en(which, cpb);
    for (int i = 0; i < 8; i++) begin
      drive(which, data[i]); wait_en(which, cpb);
    end
    if (which == 1) begin
      drive(which, p); wait_en(which, cpb);
    end
    for (int i = 0; i < nstop; i++) begin
      drive(which, (i == 0 && bad_stop) ? 1'b0 : 1'b1); wait_en(which, cpb);
    end
    drive(which, 1'b1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #2;
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic pulse_clr1();
    clr1 = 1'b1;
    wait_en(1, 1);
    clr1 = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    bit bp, bs;
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b0; en0 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid0", v0, 0);   chk("rst_count0", cnt0, 0);
    chk("rst_valid1", v1, 0);   chk("rst_count1", cnt1, 0);
    chk("rst_errs0", {fe0, pe0, ov0}, 0);
    chk("rst_errs1", {fe1, pe1, ov1}, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    // Default timing: one clean frame, then an idle-line glitch.
    send(0, 8'h51, 0, 0);
    wait_en(0, 4);
    chk("dflt_valid", v0, 1);
    chk("dflt_data", d0, 8'h51);
    chk("dflt_count", cnt0, 1);
    chk("dflt_errs", {fe0, pe0, ov0}, 0);
    rx0 = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    rx0 = 1'b1;
    repeat (1000) @(posedge clk);
    #2;
    chk("glitch_count", cnt0, 1);
    chk("glitch_errs", {fe0, pe0, ov0}, 0);
    rdy0 = 1'b1;
    @(posedge clk); #2;
    chk("pop_count0", cnt0, 0);
    chk("pop_valid0", v0, 0);
    repeat (3) @(posedge clk);
    #2;
    rdy0 = 1'b0;
    chk("empty_pop_count0", cnt0, 0);

    // Random frames with random consumer, then with clock enable stretched.
    rdy_mode = 2;
    for (int f = 0; f < 30; f++) begin
      if (f == 20) en_mode = 2;
      b  = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      exp_q.push_back(b);
      send(1, b, bp, bs);
      wait_en(1, 4);
      chk("rand_parity_err", pe1, {31'h0, bp});
      chk("rand_frame_err", fe1, {31'h0, bs});
      chk("rand_overrun", ov1, 0);
      pulse_clr1();
      chk("clr_errs", {fe1, pe1}, 0);
    end
    en_mode  = 1;
    rdy_mode = 1;
    drain();
    chk("rand_count_end", cnt1, 0);

    // Short glitch on the fast instance.
    rx1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rx1 = 1'b1;
    wait_en(1, 64);
    chk("glitch1_count", cnt1, 0);
    chk("glitch1_errs", {fe1, pe1, ov1}, 0);

    // Overflow: five bytes into four entries with no consumer.
    rdy_mode = 0;
    wait_en(1, 3);
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH1) exp_q.push_back(8'(i));
      send(1, 8'(i), 0, 0);
      wait_en(1, 4);
    end
    chk("ovf_count", cnt1, 4);
    chk("ovf_flag", ov1, 1);
    chk("ovf_head", d1, 8'h01);
    en_mode  = 0;
    rdy_mode = 1;
    repeat (10) @(posedge clk);
    #2;
    chk("clken_hold_count", cnt1, 4);
    en_mode = 1;
    drain();
    wait_en(1, 2);
    chk("ovf_drain_count", cnt1, 0);
    chk("ovf_sticky", ov1, 1);
    pulse_clr1();
    chk("ovf_cleared", ov1, 0);

    // Reset in the middle of a frame discards it and empties the FIFO.
    rdy_mode = 0;
    wait_en(1, 3);
    send(1, 8'h99, 0, 0);
    wait_en(1, 4);
    chk("pre_rst_count", cnt1, 1);
    b = 8'h7E;
    drive(1, 1'b0); wait_en(1, CPB1);
    for (int i = 0; i < 3; i++) begin
      drive(1, b[i]); wait_en(1, CPB1);
    end
    wait_en(1, CPB1 / 2);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("in_rst_valid", v1, 0);
    chk("in_rst_count", cnt1, 0);
    rx1 = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    wait_en(1, 50);
    chk("post_rst_count", cnt1, 0);
    exp_q.push_back(8'h42);
    send(1, 8'h42, 0, 0);
    wait_en(1, 4);
    chk("post_rst_frame_count", cnt1, 1);
    chk("post_rst_errs", {fe1, pe1, ov1}, 0);
    rdy_mode = 1;
    drain();
    wait_en(1, 2);
    chk("final_count", cnt1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 868, meaning clk cycles per UART bit (legal range 4..65535).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..8).
REQ-003 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits checked (1 or 2).
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 16, meaning RX FIFO entries (power of two, 2..256).
REQ-006 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-007 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-008 The block SHALL have port clkEn, input, 1, meaning clock enable; when low, every register holds its value.
REQ-009 The block SHALL have port rx, input, 1, meaning asynchronous serial line, idle high.
REQ-010 The block SHALL have port rx_data, output, 8, meaning FIFO head byte, zero-extended above DATA_BITS.
REQ-011 The block SHALL have port rx_valid, output, 1, meaning the FIFO is non-empty.
REQ-012 The block SHALL have port rx_ready, input, 1, meaning consumer pop; a pop occurs when rx_valid && rx_ready.
REQ-013 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, meaning the current occupancy.
REQ-014 The block SHALL have ports frame_err, parity_err and overrun, each output, 1, meaning sticky error flags.
REQ-015 The block SHALL have port err_clr, input, 1, meaning clear all sticky error flags.

Function
REQ-016 The block SHALL pass rx through a 2-flop synchronizer that resets to 1; the FSM uses only the synchronized value.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, with IDLE as the reset state.
REQ-018 In IDLE, a synchronized 1->0 edge SHALL move the FSM to START and load the bit counter with CLK_PER_BIT/2-1.
REQ-019 In START, at the counter terminal count, rx low SHALL move the FSM to DATA; rx high SHALL be treated as a glitch and return the FSM to IDLE with no error.
REQ-020 Each DATA, PARITY and STOP bit SHALL be sampled once, CLK_PER_BIT cycles after the previous sample (mid-bit).
REQ-021 DATA bits SHALL be received LSB first, shifted into the byte register, for exactly DATA_BITS samples.
REQ-022 The PARITY state SHALL be entered only when PARITY!=0; a mismatch against the even/odd XOR of the data bits SHALL set parity_err.
REQ-023 In STOP, a low sample on any of the STOP_BITS samples SHALL set frame_err.
REQ-024 After the last stop sample, the FSM SHALL return to IDLE, and the byte SHALL be pushed into the FIFO on the following clk edge, even if an error flag was set.
REQ-025 rx_valid SHALL rise on the cycle after the push, giving a latency of 2 cycles from the final stop sample.
REQ-026 A push when the FIFO is full and no pop occurs in the same cycle SHALL drop the byte, set overrun, and leave the FIFO contents unchanged.
REQ-027 A push and a pop in the same cycle SHALL both take effect, leaving fifo_count unchanged; this applies at full as well.
REQ-028 A pop when the FIFO is empty SHALL be ignored.
REQ-029 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL saturate at 0..FIFO_DEPTH.
REQ-030 rx_data SHALL be show-ahead: it equals the head entry whenever rx_valid is high, and is don't-care otherwise.
REQ-031 err_clr SHALL clear the sticky error flags; an error event in the same cycle as err_clr SHALL win, leaving the flag set.
REQ-032 When clkEn is low, no sample, push or pop SHALL occur, and the bit timing SHALL stretch accordingly.

Reset
REQ-033 On rst high at a clk edge, the block SHALL enter IDLE, clear the counters, empty the FIFO, and clear all error flags, with synchronizer flops set to 1.
REQ-034 During reset, rx_valid SHALL be 0 and fifo_count SHALL be 0; rst SHALL take priority over clkEn.
REQ-035 A reset mid-frame SHALL discard the partial byte; reception SHALL resume at the next falling edge after rst deasserts.

Structure
REQ-036 A shared package uart_pkg SHALL hold the FSM state enum, the parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the default CLK_PER_BIT of 868 (100 MHz, 115200 baud).
REQ-037 The FIFO SHALL be a sub-module named sync_fifo, parametrised by width and depth, reusable for the TX path.

Verification
REQ-038 With defaults, a frame 0x51 driven at 868 cycles/bit SHALL give rx_valid, rx_data=0x51, fifo_count=1, and no error flags.
REQ-039 With PARITY=1, frame 0xA5 sent with a wrong parity bit of 1 SHALL push 0xA5 and set parity_err; err_clr SHALL clear it.
REQ-040 A stop bit forced to 0 on byte 0x3C SHALL push 0x3C and set frame_err.
REQ-041 With FIFO_DEPTH=4 and rx_ready=0, sending 5 bytes 0x01..0x05 SHALL give fifo_count=4 and overrun=1, and popping SHALL return 0x01..0x04.
REQ-042 A 200-cycle low glitch on idle rx SHALL produce no push and no error.
REQ-043 Asserting rst at mid-DATA of byte 0x7E and then sending 0x42 SHALL leave only 0x42 in the FIFO.
